axi_rd_arbiter: RTL

AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

---
 rtl/axi_rd_arbiter_pkg.sv | 34 +++
 rtl/axi_rd_arbiter_pick.sv | 24 ++
 rtl/axi_rd_arbiter.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/axi_rd_arbiter_pkg.sv
// rtl/axi_rd_arbiter_pkg.sv - shared encodings for the read arbiter (states, client ids, AXI constants)
package axi_rd_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } rd_state_e;

  localparam logic [1:0] CL_ICACHE = 2'd0;
  localparam logic [1:0] CL_DCACHE = 2'd1;
  localparam logic [1:0] CL_IUNC   = 2'd2;
  localparam logic [1:0] CL_DUNC   = 2'd3;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'd2;
  localparam logic [3:0] AXI_CACHE_WB   = 4'b1111;
  localparam logic [3:0] AXI_CACHE_DEV  = 4'b0010;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  function automatic int cache_blk_size(input int blk_words);
    return 32 * blk_words;
  endfunction

  function automatic logic is_cached(input logic [1:0] idx);
    return (idx == CL_ICACHE) || (idx == CL_DCACHE);
  endfunction

  function automatic logic is_uncached(input logic [1:0] idx);
    return (idx == CL_IUNC) || (idx == CL_DUNC);
  endfunction

endpackage

// File: rtl/axi_rd_arbiter_pick.sv
// rtl/axi_rd_arbiter_pick.sv - combinational 4-way picker: first requester found from ptr upwards, mod 4
module axi_rd_arbiter_pick (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [3:0] grant
);

  logic [1:0] cand;
  logic       found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < 4; i++) begin
      cand = ptr + 2'(i);
      if (req[cand] && !found) begin
        grant[cand] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// rtl/axi_rd_arbiter.sv - single-outstanding AXI4 read arbiter for four cache/uncached clients
// Optional round-robin arbitration with RD_ARB_RR_EN; default is fixed priority 2 > 3 > 0 > 1.
module axi_rd_arbiter
  import axi_rd_arbiter_pkg::*;
#(
  parameter int         BLK_WORDS = 4,
  parameter logic [3:0] ARID      = 4'h0
) (
  input  logic                               aclk,
  input  logic                               aresetn,
  input  logic [3:0]                         req,
  input  logic [127:0]                       req_addr,
  output logic [3:0]                         ack,
  output logic [3:0]                         rsp_valid,
  output logic [cache_blk_size(BLK_WORDS)-1:0] rsp_data,
  output logic                               rsp_err,
  output logic [3:0]                         m_axi_arid,
  output logic [31:0]                        m_axi_araddr,
  output logic [7:0]                         m_axi_arlen,
  output logic [2:0]                         m_axi_arsize,
  output logic [1:0]                         m_axi_arburst,
  output logic                               m_axi_arlock,
  output logic [3:0]                         m_axi_arcache,
  output logic [2:0]                         m_axi_arprot,
  output logic                               m_axi_arvalid,
  input  logic                               m_axi_arready,
  input  logic [3:0]                         m_axi_rid,
  input  logic [31:0]                        m_axi_rdata,
  input  logic [1:0]                         m_axi_rresp,
  input  logic                               m_axi_rlast,
  input  logic                               m_axi_rvalid,
  output logic                               m_axi_rready
);

  localparam int CACHE_BLK_SIZE = cache_blk_size(BLK_WORDS);

  rd_state_e                 state_q, state_d;
  logic [1:0]                idx_q, win_idx, ptr;
  logic [3:0]                grant;
  logic [31:0]               addr_q;
  logic [2:0]                beat_cnt_q;
  logic [CACHE_BLK_SIZE-1:0] buf_q;
  logic                      err_q;
  logic [7:0]                arlen_cur;
  logic                      in_addr, ar_hs, r_beat, r_end;
  logic                      unused_rid;

  assign unused_rid = ^m_axi_rid;

  axi_rd_arbiter_pick u_pick (
    .req   (req),
    .ptr   (ptr),
    .grant (grant)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < 4; i++) begin
      if (grant[i]) win_idx = 2'(i);
    end
  end

`ifdef RD_ARB_RR_EN
  logic [1:0] ptr_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)   ptr_q <= CL_ICACHE;
    else if (ar_hs) ptr_q <= idx_q + 2'd1;
  end

  assign ptr = ptr_q;
`else
  // Fixed order 2,3,0,1 is exactly a rotating search that always starts at client 2.
  assign ptr = CL_IUNC;
`endif

  assign in_addr   = (state_q == ST_ADDR);
  assign arlen_cur = is_cached(idx_q) ? 8'(BLK_WORDS - 1) : 8'd0;
  assign ar_hs     = in_addr && m_axi_arready;
  assign r_beat    = (state_q == ST_DATA) && m_axi_rvalid;
  assign r_end     = r_beat && (m_axi_rlast || ({5'd0, beat_cnt_q} == arlen_cur));

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req != 4'd0)   state_d = ST_ADDR;
      ST_ADDR: if (m_axi_arready) state_d = ST_DATA;
      ST_DATA: if (r_end)         state_d = ST_RESP;
      ST_RESP:                    state_d = ST_IDLE;
      default:                    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      idx_q      <= '0;
      addr_q     <= '0;
      beat_cnt_q <= '0;
      buf_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && req != 4'd0) begin
        idx_q  <= win_idx;
        addr_q <= req_addr[{win_idx, 5'b0} +: 32];
      end
      if (r_beat) begin
        for (int w = 0; w < BLK_WORDS; w++) begin
          if (beat_cnt_q == 3'(w)) buf_q[32*w +: 32] <= m_axi_rdata;
        end
        beat_cnt_q <= beat_cnt_q + 3'd1;
        if (m_axi_rresp != AXI_RESP_OKAY) err_q <= 1'b1;
      end
      if (state_q == ST_RESP) begin
        beat_cnt_q <= '0;
        buf_q      <= '0;
        err_q      <= 1'b0;
      end
    end
  end

  // AR fields are held at zero outside ADDR so the bus is quiet between transfers.
  assign m_axi_arid    = ARID;
  assign m_axi_arvalid = in_addr;
  assign m_axi_araddr  = in_addr ? addr_q : 32'd0;
  assign m_axi_arlen   = in_addr ? arlen_cur : 8'd0;
  assign m_axi_arsize  = in_addr ? AXI_SIZE_4B : 3'd0;
  assign m_axi_arburst = in_addr ? AXI_BURST_INCR : 2'd0;
  assign m_axi_arcache = !in_addr ? 4'd0 : (is_uncached(idx_q) ? AXI_CACHE_DEV : AXI_CACHE_WB);
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arprot  = 3'd0;
  assign m_axi_rready  = (state_q == ST_DATA);

  assign ack       = ar_hs ? (4'b0001 << idx_q) : 4'd0;
  assign rsp_valid = (state_q == ST_RESP) ? (4'b0001 << idx_q) : 4'd0;
  assign rsp_data  = (state_q == ST_RESP) ? buf_q : '0;
  assign rsp_err   = (state_q == ST_RESP) && err_q;

endmodule
